// File: rtl/bike_input_ctrl_if.sv
// bike_input_ctrl_if: raw button/game-state inputs and orientation/run outputs of the lightbike input stage.
interface bike_input_ctrl_if;
  logic [3:0]  btn_up;
  logic [3:0]  btn_right;
  logic [3:0]  btn_down;
  logic [3:0]  btn_left;
  logic        btn_start;
  logic        game_over;
  logic [31:0] bikeoneOrient_IN;
  logic [31:0] biketwoOrient_IN;
  logic [31:0] bikethreeOrient_IN;
  logic [31:0] bikefourOrient_IN;
  logic        masterSwitch;
  logic [3:0]  turn_pulse;
  modport master (
    output btn_up, btn_right, btn_down, btn_left, btn_start, game_over,
    input  bikeoneOrient_IN, biketwoOrient_IN, bikethreeOrient_IN, bikefourOrient_IN,
           masterSwitch, turn_pulse
  );
  modport slave (
    input  btn_up, btn_right, btn_down, btn_left, btn_start, game_over,
    output bikeoneOrient_IN, biketwoOrient_IN, bikethreeOrient_IN, bikefourOrient_IN,
           masterSwitch, turn_pulse
  );
endinterface

// File: rtl/bike_input_ctrl.sv
// bike_input_ctrl: synchronizes/debounces player buttons, applies legal turns and drives the run/pause flag.
module bike_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset,
  bike_input_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] RST_OR = {2'd0, 2'd2, 2'd3, 2'd1};
  // Lane map: up[3:0], right[7:4], down[11:8], left[15:12], start[16]
  logic [16:0] raw, s1_q, s2_q, deb_q, deb_d, prev_q, press_q, press_d, diff, hit;
  logic [CNT_W-1:0] cnt_q [17];
  logic [CNT_W-1:0] cnt_d [17];
  logic [1:0] orient_q [4];
  logic [1:0] orient_d [4];
  logic [1:0] cand [4];
  logic [3:0] pulse_q, pulse_d;
  logic ms_q, ms_d;
  assign raw = {bus.btn_start, bus.btn_left, bus.btn_down, bus.btn_right, bus.btn_up};
  assign diff = s2_q ^ deb_q;
  assign press_d = deb_q & ~prev_q;
  always_comb begin
    hit = '0;
    for (int i = 0; i < 17; i++) begin
      hit[i] = diff[i] && cnt_q[i] == LIM;
      cnt_d[i] = (!diff[i] || hit[i]) ? '0 : cnt_q[i] + 1'b1;
    end
    deb_d = deb_q ^ hit;
  end
  always_comb begin
    ms_d = !bus.game_over && (ms_q ^ press_q[16]);
    pulse_d = '0;
    for (int b = 0; b < 4; b++) begin
      cand[b] = press_q[b] ? 2'd0 : press_q[4+b] ? 2'd1 : press_q[8+b] ? 2'd2 : 2'd3;
      // A reversal candidate blocks the whole cycle; lower-priority presses are not retried
      pulse_d[b] = (press_q[b] || press_q[4+b] || press_q[8+b] || press_q[12+b]) && ms_q &&
                   !bus.game_over && cand[b] != orient_q[b] + 2'd2 && cand[b] != orient_q[b];
      orient_d[b] = pulse_d[b] ? cand[b] : orient_q[b];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      deb_q <= '0;
      prev_q <= '0;
      press_q <= '0;
      ms_q <= 1'b0;
      pulse_q <= '0;
      for (int i = 0; i < 17; i++) cnt_q[i] <= '0;
      for (int b = 0; b < 4; b++) orient_q[b] <= RST_OR[2*b +: 2];
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      deb_q <= deb_d;
      prev_q <= deb_q;
      press_q <= press_d;
      ms_q <= ms_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < 17; i++) cnt_q[i] <= cnt_d[i];
      for (int b = 0; b < 4; b++) orient_q[b] <= orient_d[b];
    end
  end
  assign bus.bikeoneOrient_IN = {30'd0, orient_q[0]};
  assign bus.biketwoOrient_IN = {30'd0, orient_q[1]};
  assign bus.bikethreeOrient_IN = {30'd0, orient_q[2]};
  assign bus.bikefourOrient_IN = {30'd0, orient_q[3]};
  assign bus.masterSwitch = ms_q;
  assign bus.turn_pulse = pulse_q;
endmodule

// File: tb/tb_bike_input_ctrl.sv
// tb_bike_input_ctrl: directed checks of debounce latency, turn rules, pause/game-over and reset with DEBOUNCE_CYCLES=4.
module tb_bike_input_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int errs = 0;
  int checks = 0;
  int pcnt [4] = '{0, 0, 0, 0};
  bike_input_ctrl_if bus ();
  bike_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock)
    for (int b = 0; b < 4; b++) if (bus.turn_pulse[b] === 1'b1) pcnt[b]++;
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [16:0] v);
    {bus.btn_start, bus.btn_left, bus.btn_down, bus.btn_right, bus.btn_up} = v;
  endtask
  task automatic do_press(input logic [16:0] v);
    drive(v);
    tick(10);
    drive('0);
    tick(10);
  endtask
  task automatic chk_words(input string tag, input logic [1:0] a, b, c, d);
    chk({tag, "_b1"}, bus.bikeoneOrient_IN, {30'd0, a});
    chk({tag, "_b2"}, bus.biketwoOrient_IN, {30'd0, b});
    chk({tag, "_b3"}, bus.bikethreeOrient_IN, {30'd0, c});
    chk({tag, "_b4"}, bus.bikefourOrient_IN, {30'd0, d});
  endtask
  int p;
  initial begin
    drive('0);
    bus.game_over = 1'b0;
    tick(3);
    chk_words("rst", 2'd1, 2'd3, 2'd2, 2'd0);
    chk("rst_ms", {31'd0, bus.masterSwitch}, 32'd0);
    chk("rst_pulse", {28'd0, bus.turn_pulse}, 32'd0);
    reset = 1'b0;
    tick(20);
    chk_words("idle", 2'd1, 2'd3, 2'd2, 2'd0);
    chk("idle_ms", {31'd0, bus.masterSwitch}, 32'd0);
    chk("idle_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
    // start press: masterSwitch rises at edge k+7
    drive(17'h10000);
    tick(7);
    chk("start_early", {31'd0, bus.masterSwitch}, 32'd0);
    tick(1);
    chk("start_k7", {31'd0, bus.masterSwitch}, 32'd1);
    tick(2);
    drive('0);
    tick(10);
    chk("start_hold_release", {31'd0, bus.masterSwitch}, 32'd1);
    // up on bike1 with exact latency and one-cycle pulse
    drive(17'h00001);
    tick(7);
    chk("up_early_word", bus.bikeoneOrient_IN, 32'd1);
    chk("up_early_pulse", {28'd0, bus.turn_pulse}, 32'd0);
    tick(1);
    chk("up_k7_word", bus.bikeoneOrient_IN, 32'd0);
    chk("up_k7_pulse", {28'd0, bus.turn_pulse}, 32'h1);
    tick(1);
    chk("up_pulse_end", {28'd0, bus.turn_pulse}, 32'd0);
    tick(8);
    chk("up_hold_one_pulse", pcnt[0], 1);
    drive('0);
    tick(10);
    // bike1 back to right, then left is a reversal, then down is legal
    do_press(17'h00010);
    chk("b1_right", bus.bikeoneOrient_IN, 32'd1);
    p = pcnt[0];
    do_press(17'h01000);
    chk("b1_left_rev", bus.bikeoneOrient_IN, 32'd1);
    chk("b1_left_nopulse", pcnt[0], p);
    do_press(17'h00100);
    chk("b1_down", bus.bikeoneOrient_IN, 32'd2);
    chk("b1_down_pulse", pcnt[0], p + 1);
    // bounce on right[1] in 2-cycle runs never debounces
    p = pcnt[1];
    for (int i = 0; i < 10; i++) begin
      drive(i % 2 == 0 ? 17'h00020 : 17'h0);
      tick(2);
    end
    drive('0);
    tick(10);
    chk("bounce_b2", bus.biketwoOrient_IN, 32'd3);
    chk("bounce_nopulse", pcnt[1], p);
    // up+left on bike3 (down): up wins priority and is a reversal, left not tried
    p = pcnt[2];
    do_press(17'h04004);
    chk("b3_rev_word", bus.bikethreeOrient_IN, 32'd2);
    chk("b3_rev_nopulse", pcnt[2], p);
    // all bikes turn together: b1 2->1, b2 3->0, b3 2->3, b4 0->1
    drive(17'h04000 | 17'h00002 | 17'h00010 | 17'h00080);
    tick(7);
    chk("all_early", {28'd0, bus.turn_pulse}, 32'd0);
    tick(1);
    chk("all_pulse", {28'd0, bus.turn_pulse}, 32'hf);
    chk_words("all", 2'd1, 2'd0, 2'd3, 2'd1);
    tick(1);
    chk("all_pulse_end", {28'd0, bus.turn_pulse}, 32'd0);
    drive('0);
    tick(10);
    // game over forces pause and swallows presses
    bus.game_over = 1'b1;
    tick(1);
    chk("go_ms", {31'd0, bus.masterSwitch}, 32'd0);
    do_press(17'h10000);
    chk("go_start_ignored", {31'd0, bus.masterSwitch}, 32'd0);
    do_press(17'h00001);
    chk("go_turn_ignored", bus.bikeoneOrient_IN, 32'd1);
    bus.game_over = 1'b0;
    tick(2);
    chk("go_clear_still_paused", {31'd0, bus.masterSwitch}, 32'd0);
    do_press(17'h00008);
    chk("paused_turn_ignored", bus.bikefourOrient_IN, 32'd1);
    tick(10);
    chk("paused_not_queued", bus.bikefourOrient_IN, 32'd1);
    // reset mid-debounce of a held start: must re-debounce from zero
    drive(17'h10000);
    tick(4);
    reset = 1'b1;
    tick(1);
    chk_words("mid_rst", 2'd1, 2'd3, 2'd2, 2'd0);
    chk("mid_rst_ms", {31'd0, bus.masterSwitch}, 32'd0);
    chk("mid_rst_pulse", {28'd0, bus.turn_pulse}, 32'd0);
    reset = 1'b0;
    tick(7);
    chk("redebounce_early", {31'd0, bus.masterSwitch}, 32'd0);
    tick(1);
    chk("redebounce_k7", {31'd0, bus.masterSwitch}, 32'd1);
    drive('0);
    tick(10);
    chk_words("final", 2'd1, 2'd3, 2'd2, 2'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
